// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator bus logic: cycle states, defaults,
// speed encoding and small helpers.
package accel_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_ACK  = 3'd2,
    S_EXT  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  localparam int DEF_NUM_REGIONS    = 4;
  localparam int DEF_WS_WIDTH       = 3;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  localparam logic SPEED_7M  = 1'b1;
  localparam logic SPEED_14M = 1'b0;

  // Index width that stays at least one bit for single-entry vectors.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cycle_term_if.sv
// Bus-side signal bundle of the cycle terminator: CPU strobes, decoder hits,
// wait-state configuration, DMA handshake and the termination outputs.
interface cycle_term_if
  import accel_pkg::*;
#(
  parameter int NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int WS_WIDTH    = DEF_WS_WIDTH
);
  localparam int AW = idx_width(NUM_REGIONS);

  logic                            AS_CPU_n;
  logic                            DS_n;
  logic [NUM_REGIONS-1:0]          REGION_HIT;
  logic [NUM_REGIONS*WS_WIDTH-1:0] WS_CFG;
  logic                            DTACK_MB_n;
  logic                            SPEED_REQ;
  logic                            BG_n;
  logic                            FAST_DTACK_n;
  logic                            BERR_n;
  logic                            CPU_SPEED;
  logic                            DMAREQ_n;
  logic [AW-1:0]                   ACTIVE_REGION;

  modport slave (
    input  AS_CPU_n, DS_n, REGION_HIT, WS_CFG, DTACK_MB_n, SPEED_REQ, BG_n,
    output FAST_DTACK_n, BERR_n, CPU_SPEED, DMAREQ_n, ACTIVE_REGION
  );

  modport master (
    output AS_CPU_n, DS_n, REGION_HIT, WS_CFG, DTACK_MB_n, SPEED_REQ, BG_n,
    input  FAST_DTACK_n, BERR_n, CPU_SPEED, DMAREQ_n, ACTIVE_REGION
  );

endinterface

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag; shared by decoders.
module prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cycle_term.sv
// 68000 bus-cycle terminator: per-region wait states, bus-error timeout for
// unclaimed cycles, idle-window CPU speed switching and DMA request handshake.
module cycle_term
  import accel_pkg::*;
#(
  parameter int NUM_REGIONS    = DEF_NUM_REGIONS,
  parameter int WS_WIDTH       = DEF_WS_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic         C14M,
  input  logic         RESET_n,
  cycle_term_if.slave  bus
);

  localparam int AW = idx_width(NUM_REGIONS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] ST_IDLE = S_IDLE;
  localparam logic [2:0] ST_WAIT = S_WAIT;
  localparam logic [2:0] ST_ACK  = S_ACK;
  localparam logic [2:0] ST_EXT  = S_EXT;
  localparam logic [2:0] ST_ERR  = S_ERR;

  localparam logic [TW-1:0]       TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]       TCNT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [WS_WIDTH-1:0] CNT_ONE   = WS_WIDTH'(1);

  logic [2:0]          state_reg, state_next;
  logic [WS_WIDTH-1:0] cnt_reg, cnt_next;
  logic [TW-1:0]       tcnt_reg, tcnt_next;
  logic [AW-1:0]       region_reg, region_next;
  logic                claimed_reg, claimed_next;
  logic                fast_dtack_n_reg;
  logic                berr_n_reg;
  logic                dmareq_n_reg;
  logic                cpu_speed_reg;
  logic                sync1_reg, sync2_reg;

  logic [AW-1:0]       hit_idx;
  logic                hit_valid;
  logic                cycle_start;
  logic [WS_WIDTH-1:0] ws_arr [NUM_REGIONS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_ws
      assign ws_arr[gi] = bus.WS_CFG[gi*WS_WIDTH +: WS_WIDTH];
    end
  endgenerate

  prio_enc #(
    .N (NUM_REGIONS),
    .W (AW)
  ) u_prio_enc (
    .req   (bus.REGION_HIT),
    .idx   (hit_idx),
    .valid (hit_valid)
  );

  // A granted DMA master owns the bus, so no new CPU cycle may begin.
  assign cycle_start = (state_reg == ST_IDLE) && !bus.AS_CPU_n && !bus.DS_n
                       && dmareq_n_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    tcnt_next    = tcnt_reg;
    region_next  = region_reg;
    claimed_next = claimed_reg;
    if (state_reg != ST_IDLE && bus.AS_CPU_n) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cycle_start) begin
            if (hit_valid) begin
              region_next = hit_idx;
              cnt_next    = ws_arr[hit_idx];
              state_next  = (ws_arr[hit_idx] == '0) ? ST_ACK : ST_WAIT;
            end else begin
              tcnt_next    = '0;
              claimed_next = 1'b0;
              state_next   = ST_EXT;
            end
          end
        end
        ST_WAIT: begin
          cnt_next = cnt_reg - CNT_ONE;
          if (cnt_reg <= CNT_ONE) state_next = ST_ACK;
        end
        ST_EXT: begin
          if (tcnt_reg != TCNT_MAX) tcnt_next = tcnt_reg + 1'b1;
          // Once the motherboard claims the cycle the timeout is disarmed.
          if (!bus.DTACK_MB_n) claimed_next = 1'b1;
          else if (!claimed_reg && tcnt_reg >= TCNT_LAST) state_next = ST_ERR;
        end
        ST_ACK, ST_ERR: ;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge C14M or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      tcnt_reg         <= '0;
      region_reg       <= '0;
      claimed_reg      <= 1'b0;
      fast_dtack_n_reg <= 1'b1;
      berr_n_reg       <= 1'b1;
      dmareq_n_reg     <= 1'b1;
      cpu_speed_reg    <= SPEED_7M;
      sync1_reg        <= SPEED_7M;
      sync2_reg        <= SPEED_7M;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      tcnt_reg         <= tcnt_next;
      region_reg       <= region_next;
      claimed_reg      <= claimed_next;
      fast_dtack_n_reg <= !(state_reg == ST_ACK && !bus.AS_CPU_n);
      berr_n_reg       <= !(state_next == ST_ERR);
      sync1_reg        <= bus.SPEED_REQ;
      sync2_reg        <= sync1_reg;
      // Speed only switches between cycles so CLKCPU never glitches mid-cycle.
      if (state_reg == ST_IDLE && bus.AS_CPU_n) cpu_speed_reg <= sync2_reg;
      if (bus.BG_n) dmareq_n_reg <= 1'b1;
      else if (state_reg == ST_IDLE && bus.AS_CPU_n) dmareq_n_reg <= 1'b0;
    end
  end

  assign bus.FAST_DTACK_n  = fast_dtack_n_reg;
  assign bus.BERR_n        = berr_n_reg;
  assign bus.CPU_SPEED     = cpu_speed_reg;
  assign bus.DMAREQ_n      = dmareq_n_reg;
  assign bus.ACTIVE_REGION = region_reg;

endmodule

// File: doc/cycle_term.md
# cycle_term

Parametrised bus-cycle terminator for the 68000 accelerator. It replaces the fixed single-rate fast-DTACK logic with per-region programmable wait states, a bus-error timeout for unclaimed cycles, glitch-free CPU speed switching at cycle boundaries, and registered DMA-request handshaking. It sits between the address decoders (fast RAM, IDE, future regions) and the CPU's DTACK/BERR wiring in the top level, clocked from C14M.

## Interface
- NUM_REGIONS, 4, number of local address regions with their own termination
- WS_WIDTH, 3, bits per wait-state count (0..2^WS_WIDTH-1 C14M cycles)
- TIMEOUT_CYCLES, 255, C14M cycles an unclaimed cycle may run before bus error
- C14M  in  1  clock; all state changes on rising edge
- RESET_n  in  1  reset, asynchronous, active-low
- AS_CPU_n  in  1  CPU address strobe
- DS_n  in  1  combined data strobe (UDS_n & LDS_n)
- REGION_HIT  in  NUM_REGIONS  decoder hits, one bit per region
- WS_CFG  in  NUM_REGIONS*WS_WIDTH  wait-state count per region, region i at [i*WS_WIDTH +: WS_WIDTH]
- DTACK_MB_n  in  1  motherboard/6800 termination
- SPEED_REQ  in  1  speed switch, asynchronous (1 = 7 MHz, 0 = 14 MHz)
- BG_n  in  1  bus grant
- FAST_DTACK_n  out  1  local-region termination, registered
- BERR_n  out  1  bus error on timeout, registered
- CPU_SPEED  out  1  selected speed, drives the CLKCPU mux
- DMAREQ_n  out  1  bus released to DMA master
- ACTIVE_REGION  out  $clog2(NUM_REGIONS)  index of region being terminated (debug)

## Operation
- States: IDLE, WAIT, ACK, EXT, ERR.
- IDLE: when AS_CPU_n=0 and DS_n=0:
  - any REGION_HIT set: the lowest set index i wins. Load cnt=WS_CFG[i] and ACTIVE_REGION=i. Go to ACK if cnt=0, else WAIT.
  - no hit: clear tcnt and go to EXT.
- WAIT: cnt decrements each cycle. At cnt=1, go to ACK.
- ACK: FAST_DTACK_n=0. Held until AS_CPU_n=1 is sampled.
- EXT: tcnt increments each cycle.
  - DTACK_MB_n=0: stay in EXT with no timeout until AS_CPU_n=1.
  - tcnt=TIMEOUT_CYCLES-1 and DTACK_MB_n=1: go to ERR.
- ERR: BERR_n=0 until AS_CPU_n=1.
- AS_CPU_n=1 sampled in any non-IDLE state: next state is IDLE. FAST_DTACK_n and BERR_n are 1 from that cycle onward. This covers cycle abort.
- REGION_HIT changes after the cycle starts are ignored; the region is latched.
- Speed: SPEED_REQ passes through a 2-flop synchroniser. CPU_SPEED loads the synchronised value only in IDLE with AS_CPU_n=1. It never changes mid-cycle.
- DMA: DMAREQ_n goes to 0 when BG_n=0, AS_CPU_n=1 and state=IDLE. It returns to 1 on the first cycle with BG_n=1. While DMAREQ_n=0, new cycles are not started (IDLE holds).
- Reset values: FAST_DTACK_n=1, BERR_n=1, DMAREQ_n=1, CPU_SPEED=1, ACTIVE_REGION=0, state=IDLE, cnt=0, tcnt=0, synchroniser=1.

## Timing
- The cycle that samples a hit is edge 0. FAST_DTACK_n falls after edge 1 + WS_CFG[i], so a zero-wait region asserts one cycle after the hit.
- Termination release: outputs go high one edge after AS_CPU_n=1 is sampled.
- Timeout: BERR_n falls TIMEOUT_CYCLES edges after EXT entry.
- Speed change latency: 2–3 edges after SPEED_REQ toggles, gated to the bus-idle window.
- tcnt width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- RESET_n low mid-cycle forces all outputs to their reset values immediately (asynchronous assertion).

## Structure
- Shared package `accel_pkg`:
  - state enum (IDLE/WAIT/ACK/EXT/ERR)
  - default WS and timeout constants
  - speed encoding constants SPEED_7M=1 and SPEED_14M=0
- One sub-module `prio_enc`: parametrised lowest-index priority encoder producing the index and a valid bit. It is reused by future decoders.
- The synchroniser is inline.

## Test plan
- Setup: WS_CFG={3,0,2,1}; assert AS/DS with REGION_HIT=4'b0100. Expect FAST_DTACK_n low 3 edges after hit sample and ACTIVE_REGION=2. Raise AS; FAST_DTACK_n high one edge later.
- REGION_HIT=4'b0110: region 1 wins. FAST_DTACK_n low after 1 edge (WS=0).
- No hit, DTACK_MB_n held 1, TIMEOUT_CYCLES=16: BERR_n low at edge 16 and held until AS rises. With DTACK_MB_n=0 at edge 5, no BERR.
- Region 0 cycle; toggle SPEED_REQ 1→0 mid-WAIT. CPU_SPEED stays 1 until AS_CPU_n=1 and IDLE, then becomes 0 within 3 edges.
- BG_n=0 during an active cycle: DMAREQ_n stays 1 until AS rises, then goes 0. A new AS/DS with a hit is not terminated. BG_n=1 returns DMAREQ_n to 1 next edge.
- RESET_n pulsed low in WAIT with FAST_DTACK_n pending: all outputs are at reset values asynchronously, and the state is IDLE after release.
